hilo_acc_bank: RTL and testbench
================================

Name: hilo_acc_bank

Overview:
Parametrised successor to the single HI/LO pair: a bank of NUM_ACC HI/LO accumulator channels.
- Supports direct writes plus multiply, multiply-accumulate and multiply-subtract operations.
- Multiply-class ops go through a pipelined multiplier with in-order commit and a per-channel busy scoreboard.
- Sits beside the EX stage. The decoder issues requests; EX/MEM reads a channel.

Parameters:
DATA_W, 32, width of each HI and LO half.
NUM_ACC, 4, number of HI/LO channels (>=1).
ACC_W, max(1,clog2(NUM_ACC)), channel index width (derived, localparam).
MUL_STAGES, 2, multiplier pipeline depth (>=1).

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low.
flush  in  1  discard all in-flight multiply-class ops.
req_valid  in  1  request present.
req_ready  out  1  request accepted on the edge when valid&ready.
req_op  in  4  operation code (see Behaviour).
req_acc  in  ACC_W  target channel.
req_a  in  DATA_W  operand A / HI write data.
req_b  in  DATA_W  operand B / LO write data.
rd_acc  in  ACC_W  read channel select.
hi_o  out  DATA_W  HI of rd_acc (combinational from registers).
lo_o  out  DATA_W  LO of rd_acc.
rd_busy  out  1  busy[rd_acc]; hi_o/lo_o are stale while high.
busy  out  NUM_ACC  per-channel pending multiply-class op.

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-low: when rst==0 at posedge, all channels' HI/LO are set to 0, the pipeline valid bits and busy are cleared, and any op in flight is dropped.
- Reset values: req_ready=0 during reset, busy=0, rd_busy=0, hi_o=lo_o=0.

Ops (req_op):
- 0 NOP.
- 1 MTHI: hi<=a.
- 2 MTLO: lo<=a.
- 3 WRITE: hi<=a, lo<=b.
- 4 MULT: {hi,lo}<=signed a*b.
- 5 MULTU: unsigned a*b.
- 6 MADD: {hi,lo}+=signed a*b.
- 7 MADDU: {hi,lo}+=unsigned a*b.
- 8 MSUB: {hi,lo}-=signed a*b.
- 9 MSUBU: {hi,lo}-=unsigned a*b.
- 10-15 treated as NOP (accepted, no effect).

Arithmetic:
- Product is 2*DATA_W bits.
- Accumulate and subtract wrap modulo 2^(2*DATA_W). No overflow flag.

Timing:
- Direct writes (ops 1-3) commit on the accept edge. Visible on hi_o/lo_o the following cycle.
- Multiply-class ops (4-9) enter the multiplier on the accept edge. After MUL_STAGES edges the product reaches the commit stage.
- The commit stage reads the channel register and writes the result on the next edge. Total latency is MUL_STAGES+1 edges from accept to visible.
- Throughput is one request per cycle.

Scoreboard:
- Per-channel counter of in-flight multiply-class ops, width clog2(MUL_STAGES+2).
- busy[i] = (count!=0).
- Increment on accept; decrement on commit. Same-cycle increment and decrement on one channel leaves the count unchanged.

Hazards:
- Back-to-back MADD/MSUB to the same channel need no stall. The commit stage always reads the register already updated by the prior commit.
- A direct write to a channel with busy=1 stalls: req_ready=0 until busy clears. This preserves program order (WAW).
- Multiply-class ops are never stalled by busy.
- A commit and a direct write to different channels on the same edge both take effect.
- The same-channel case is impossible by construction.

Flush:
- On the edge where flush=1, all pipeline valid bits and all busy counts are cleared, and no commit occurs.
- req_ready=0 while flush=1.
- A direct write already committed earlier is unaffected.

Reset mid-operation overrides everything, including flush.

Decomposition:
- Package hilo_pkg: op encodings (OP_NOP..OP_MSUBU), op-class helper constants (IS_MUL mask, IS_ACC, IS_SUB, IS_SIGNED bits).
- Sub-module hilo_mul_pipe (DATA_W, MUL_STAGES): signed/unsigned multiplier with a registered valid/acc/op sideband.
- Top module holds the register bank, scoreboard, commit adder, hazard logic and read mux.

Test Plan:
All tests use DATA_W=32, NUM_ACC=4, MUL_STAGES=2.
1. Reset: hold rst=0 for 2 cycles with req_valid=1 WRITE -> all hi_o/lo_o=0, busy=0000, req_ready=0. No write lands.
2. WRITE acc2 a=0xDEADBEEF b=0x12345678, then MTLO acc2 a=0x1 -> next cycle rd_acc=2 reads 0xDEADBEEF/0x12345678, then lo=0x00000001.
3. MULT acc1 a=0xFFFFFFFF b=0x2 (signed) -> busy[1]=1 for 3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands gives hi=0x00000001, lo=0xFFFFFFFE.
4. Back-to-back MADDU acc0 (a=0x80000000,b=2) three times from zero -> final hi=0x00000003, lo=0x00000000, 5 cycles after the first accept. No stall.
5. MULT acc3 then immediately MTHI acc3 -> req_ready=0 for 3 cycles until busy[3] clears. MTHI value wins. A concurrent MTHI to acc0 is accepted immediately.
6. MSUB acc1 in flight; assert flush one cycle later -> acc1 unchanged, busy=0000, req_ready=0 during the flush cycle.

Source files
------------

// File: rtl/hilo_pkg.sv
// HI/LO accumulator bank: op encodings and op-class masks indexed by op code.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MTHI  = 4'd1,
    OP_MTLO  = 4'd2,
    OP_WRITE = 4'd3,
    OP_MULT  = 4'd4,
    OP_MULTU = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } hilo_op_e;

  // Bit n of each mask set means op code n belongs to that class; codes 10-15 fall in none.
  localparam logic [15:0] IS_DIRECT = 16'h000E;
  localparam logic [15:0] IS_MUL    = 16'h03F0;
  localparam logic [15:0] IS_ACC    = 16'h03C0;
  localparam logic [15:0] IS_SUB    = 16'h0300;
  localparam logic [15:0] IS_SIGNED = 16'h0150;

  function automatic logic op_in(input logic [15:0] mask, input logic [3:0] op);
    return mask[op];
  endfunction

endpackage

// File: rtl/hilo_mul_pipe.sv
// Signed/unsigned DATA_W x DATA_W multiplier: operand register plus MUL_STAGES product stages,
// with channel/op sideband travelling alongside. Output is the commit stage.
module hilo_mul_pipe
  import hilo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2,
  parameter int ACC_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_vld_i,
  input  logic [ACC_W-1:0]      in_acc_i,
  input  logic [3:0]            in_op_i,
  input  logic [DATA_W-1:0]     in_a_i,
  input  logic [DATA_W-1:0]     in_b_i,
  output logic                  out_vld_o,
  output logic [ACC_W-1:0]      out_acc_o,
  output logic [3:0]            out_op_o,
  output logic [2*DATA_W-1:0]   out_prod_o
);

  localparam int PW = 2 * DATA_W;

  logic [MUL_STAGES:0]             vld_pipe;
  logic [MUL_STAGES:0][ACC_W-1:0]  acc_q;
  logic [MUL_STAGES:0][3:0]        op_q;
  logic [MUL_STAGES:1][PW-1:0]     prod_q;
  logic [DATA_W-1:0]               a_q, b_q;
  logic                            sgn;
  logic [PW-1:0]                   a_ext, b_ext, prod;

  // Extend to full width first; the low PW bits of the product are then exact for both signednesses.
  always_comb begin
    sgn   = op_in(IS_SIGNED, op_q[0]);
    a_ext = {{DATA_W{sgn & a_q[DATA_W-1]}}, a_q};
    b_ext = {{DATA_W{sgn & b_q[DATA_W-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) vld_pipe <= '0;
    else               vld_pipe <= {vld_pipe[MUL_STAGES-1:0], in_vld_i};
  end

  always_ff @(posedge clk) begin
    if (in_vld_i) begin
      a_q      <= in_a_i;
      b_q      <= in_b_i;
      acc_q[0] <= in_acc_i;
      op_q[0]  <= in_op_i;
    end
    prod_q[1] <= prod;
    for (int s = 1; s <= MUL_STAGES; s++) begin
      acc_q[s] <= acc_q[s-1];
      op_q[s]  <= op_q[s-1];
    end
    for (int s = 2; s <= MUL_STAGES; s++) prod_q[s] <= prod_q[s-1];
  end

  assign out_vld_o  = vld_pipe[MUL_STAGES];
  assign out_acc_o  = acc_q[MUL_STAGES];
  assign out_op_o   = op_q[MUL_STAGES];
  assign out_prod_o = prod_q[MUL_STAGES];

endmodule

// File: rtl/hilo_acc_bank.sv
// Bank of NUM_ACC HI/LO accumulators: direct writes, pipelined multiply/MAC/MSUB with in-order
// commit, per-channel in-flight counters, WAW stall for direct writes and a combinational read port.
module hilo_acc_bank
  import hilo_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  NUM_ACC    = 4,
  parameter int  MUL_STAGES = 2,
  localparam int ACC_W      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [ACC_W-1:0]   req_acc,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  input  logic [ACC_W-1:0]   rd_acc,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o,
  output logic               rd_busy,
  output logic [NUM_ACC-1:0] busy
);

  localparam int CNT_W = $clog2(MUL_STAGES + 2);

  logic [DATA_W-1:0] hi_q [NUM_ACC];
  logic [DATA_W-1:0] lo_q [NUM_ACC];
  logic [CNT_W-1:0]  cnt_q [NUM_ACC];

  logic                is_direct, is_mul, acc_busy, accept, wr_en, mul_en;
  logic [NUM_ACC-1:0]  cm_hit, wr_hit, inc;
  logic                mp_vld, cm_vld;
  logic [ACC_W-1:0]    cm_acc;
  logic [3:0]          cm_op;
  logic [2*DATA_W-1:0] cm_prod, cm_cur, cm_res;

  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) busy[i] = (cnt_q[i] != '0);
  end

  // Direct writes wait for their channel to drain so they land after older multiply results.
  always_comb begin
    is_direct = op_in(IS_DIRECT, req_op);
    is_mul    = op_in(IS_MUL, req_op);
    acc_busy  = 1'b0;
    for (int i = 0; i < NUM_ACC; i++)
      if (req_acc == ACC_W'(i)) acc_busy = busy[i];
    req_ready = rst && !flush && !(is_direct && acc_busy);
    accept    = req_valid && req_ready;
    wr_en     = accept && is_direct;
    mul_en    = accept && is_mul;
  end

  hilo_mul_pipe #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES),
    .ACC_W      (ACC_W)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_vld_i   (mul_en),
    .in_acc_i   (req_acc),
    .in_op_i    (req_op),
    .in_a_i     (req_a),
    .in_b_i     (req_b),
    .out_vld_o  (mp_vld),
    .out_acc_o  (cm_acc),
    .out_op_o   (cm_op),
    .out_prod_o (cm_prod)
  );

  assign cm_vld = mp_vld && !flush;

  // Commit reads the live register, so a preceding commit to the same channel is already included.
  always_comb begin
    cm_cur = '0;
    for (int i = 0; i < NUM_ACC; i++)
      if (cm_acc == ACC_W'(i)) cm_cur = {hi_q[i], lo_q[i]};
    if (!op_in(IS_ACC, cm_op))     cm_res = cm_prod;
    else if (op_in(IS_SUB, cm_op)) cm_res = cm_cur - cm_prod;
    else                           cm_res = cm_cur + cm_prod;
  end

  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      cm_hit[i] = cm_vld && (cm_acc == ACC_W'(i));
      wr_hit[i] = wr_en  && (req_acc == ACC_W'(i));
      inc[i]    = mul_en && (req_acc == ACC_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACC; i++) begin
      if (!rst) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end else if (cm_hit[i]) begin
        {hi_q[i], lo_q[i]} <= cm_res;
      end else if (wr_hit[i]) begin
        if (req_op != OP_MTLO) hi_q[i] <= req_a;
        if (req_op == OP_MTLO)       lo_q[i] <= req_a;
        else if (req_op == OP_WRITE) lo_q[i] <= req_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACC; i++) begin
      if (!rst || flush)              cnt_q[i] <= '0;
      else if (inc[i] && !cm_hit[i])  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      else if (!inc[i] && cm_hit[i])  cnt_q[i] <= cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    rd_busy = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (rd_acc == ACC_W'(i)) begin
        hi_o    = hi_q[i];
        lo_o    = lo_q[i];
        rd_busy = busy[i];
      end
    end
  end

endmodule

// File: tb/tb_hilo_acc_bank.sv
// Bench for hilo_acc_bank: a reference model pushes expected HI/LO per op with its due cycle;
// the scoreboard pops and compares when that cycle arrives.
module tb_hilo_acc_bank;
  import hilo_pkg::*;

  localparam int DW = 32;
  localparam int NA = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'd0;
  logic [AW-1:0] req_acc = '0;
  logic [DW-1:0] req_a = '0;
  logic [DW-1:0] req_b = '0;
  logic [AW-1:0] rd_acc = '0;
  logic [DW-1:0] hi_o, lo_o;
  logic          rd_busy;
  logic [NA-1:0] busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            due;
    logic [AW-1:0] acc;
    logic [3:0]    op;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_hi [NA];
  logic [DW-1:0] m_lo [NA];

  hilo_acc_bank #(.DATA_W(DW), .NUM_ACC(NA), .MUL_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_acc   (req_acc),
    .req_a     (req_a),
    .req_b     (req_b),
    .rd_acc    (rd_acc),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .rd_busy   (rd_busy),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_prod(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sv;
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB) begin
      sa = longint'($signed(a));
      sv = longint'($signed(b));
      return 64'(sa * sv);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Called when the request will be accepted on the next edge (cyc+1).
  task automatic model_push(logic [3:0] op, logic [AW-1:0] acc, logic [31:0] a, logic [31:0] b);
    logic [63:0] cur, p;
    exp_t e;
    cur = {m_hi[acc], m_lo[acc]};
    p   = ref_prod(op, a, b);
    case (op)
      OP_MTHI:            m_hi[acc] = a;
      OP_MTLO:            m_lo[acc] = a;
      OP_WRITE:           begin m_hi[acc] = a; m_lo[acc] = b; end
      OP_MULT, OP_MULTU:  {m_hi[acc], m_lo[acc]} = p;
      OP_MADD, OP_MADDU:  {m_hi[acc], m_lo[acc]} = cur + p;
      OP_MSUB, OP_MSUBU:  {m_hi[acc], m_lo[acc]} = cur - p;
      default: ;
    endcase
    e.due = cyc + ((op >= 4'd4) ? 4 : 1);
    e.acc = acc;
    e.op  = op;
    e.hi  = m_hi[acc];
    e.lo  = m_lo[acc];
    if (op >= 4'd1 && op <= 4'd9) sb.push_back(e);
  endtask

  task automatic sb_poll();
    logic [AW-1:0] save;
    save = rd_acc;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due <= cyc) begin
        rd_acc = sb[k].acc;
        #1;
        total++;
        if (sb[k].due != cyc || hi_o !== sb[k].hi || lo_o !== sb[k].lo) begin
          bad++;
          $display("FAIL sb_op%0d_acc%0d cyc%0d: got %h_%h want %h_%h due%0d",
                   sb[k].op, sb[k].acc, cyc, hi_o, lo_o, sb[k].hi, sb[k].lo, sb[k].due);
        end
        sb.delete(k);
      end
    end
    rd_acc = save;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_poll();
  endtask

  task automatic issue(logic [3:0] op, logic [AW-1:0] acc, logic [31:0] a, logic [31:0] b,
                       bit trk, output int stalls);
    req_valid = 1'b1;
    req_op    = op;
    req_acc   = acc;
    req_a     = a;
    req_b     = b;
    stalls    = 0;
    #1;
    while (!req_ready && stalls < 20) begin
      step();
      stalls++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout op%0d acc%0d: got ready=%b want 1", op, acc, req_ready);
      req_valid = 1'b0;
      return;
    end
    if (trk) model_push(op, acc, a, b);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_rd(string name, logic [AW-1:0] acc, logic [31:0] hi, logic [31:0] lo);
    rd_acc = acc;
    #1;
    total++;
    if (hi_o !== hi || lo_o !== lo) begin
      bad++;
      $display("FAIL %s: got %h_%h want %h_%h", name, hi_o, lo_o, hi, lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; req_op = OP_WRITE; req_acc = 0;
    req_a = 32'hDEADBEEF; req_b = 32'hCAFEF00D;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    end
    total++;
    if (busy !== 4'b0000) begin bad++; $display("FAIL reset_busy: got %b want 0000", busy); end
    for (int i = 0; i < NA; i++) begin
      m_hi[i] = '0; m_lo[i] = '0;
      check_rd($sformatf("reset_acc%0d", i), AW'(i), 32'h0, 32'h0);
      total++;
      if (rd_busy !== 1'b0) begin bad++; $display("FAIL reset_rd_busy%0d: got %b want 0", i, rd_busy); end
    end
    req_valid = 1'b0; rst = 1'b1;
    step();
    check_rd("reset_no_write", 0, 32'h0, 32'h0);
  endtask

  task automatic test_direct();
    int st;
    issue(OP_WRITE, 2, 32'hDEADBEEF, 32'h12345678, 1'b1, st);
    check_rd("write_acc2", 2, 32'hDEADBEEF, 32'h12345678);
    issue(OP_MTLO, 2, 32'h1, 32'h0, 1'b1, st);
    check_rd("mtlo_acc2", 2, 32'hDEADBEEF, 32'h00000001);
  endtask

  task automatic test_mult();
    int st;
    issue(OP_MULT, 1, 32'hFFFFFFFF, 32'h2, 1'b1, st);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (busy[1] !== 1'b1) begin bad++; $display("FAIL mult_busy_c%0d: got %b want 1", c, busy[1]); end
      step();
    end
    total++;
    if (busy[1] !== 1'b0) begin bad++; $display("FAIL mult_busy_clear: got %b want 0", busy[1]); end
    check_rd("mult_signed", 1, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(OP_MULTU, 1, 32'hFFFFFFFF, 32'h2, 1'b1, st);
    drain(10);
    check_rd("multu", 1, 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_back_to_back();
    int st, t0;
    issue(OP_WRITE, 0, 32'h0, 32'h0, 1'b1, st);
    t0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      issue(OP_MADDU, 0, 32'h80000000, 32'h2, 1'b1, st);
      total++;
      if (st !== 0) begin bad++; $display("FAIL maddu_stall%0d: got %0d want 0", k, st); end
    end
    drain(10);
    total++;
    if (cyc - t0 !== 5) begin bad++; $display("FAIL maddu_latency: got %0d want 5", cyc - t0); end
    check_rd("maddu_final", 0, 32'h00000003, 32'h00000000);
    issue(OP_MSUB, 0, 32'hFFFFFFFF, 32'h3, 1'b1, st);
    issue(OP_MADD, 0, 32'h7FFFFFFF, 32'h80000000, 1'b1, st);
    issue(OP_MSUBU, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, st);
    drain(10);
  endtask

  task automatic test_stall();
    int st;
    issue(OP_MULT, 3, 32'h5, 32'h7, 1'b1, st);
    issue(OP_MTHI, 3, 32'hAAAA5555, 32'h0, 1'b1, st);
    total++;
    if (st !== 3) begin bad++; $display("FAIL mthi_stall: got %0d want 3", st); end
    drain(10);
    check_rd("mthi_wins", 3, 32'hAAAA5555, 32'h00000023);
    issue(OP_MULT, 3, 32'h3, 32'h3, 1'b1, st);
    issue(OP_MTHI, 0, 32'h0BADF00D, 32'h0, 1'b1, st);
    total++;
    if (st !== 0) begin bad++; $display("FAIL mthi_other_stall: got %0d want 0", st); end
    total++;
    if (busy !== 4'b1000) begin bad++; $display("FAIL busy_acc3_only: got %b want 1000", busy); end
    drain(10);
  endtask

  task automatic test_flush();
    int st;
    issue(OP_WRITE, 1, 32'h11111111, 32'h22222222, 1'b1, st);
    issue(OP_MSUB, 1, 32'h3, 32'h4, 1'b0, st);
    total++;
    if (busy[1] !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", busy[1]); end
    flush = 1'b1; req_valid = 1'b1; req_op = OP_NOP; req_acc = 2;
    #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    total++;
    if (busy !== 4'b0000) begin bad++; $display("FAIL flush_busy: got %b want 0000", busy); end
    repeat (4) step();
    check_rd("flush_unchanged", 1, 32'h11111111, 32'h22222222);
  endtask

  initial begin
    test_reset();
    test_direct();
    test_mult();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
